// File: rtl/regwr_pkg.sv
// Shared types and helpers for the register-write strobe front end.
package regwr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEC    = 2'd1,
        STROBE = 2'd2,
        ACK    = 2'd3
    } state_t;

    // Clear-all alias sits this far past the last real register (BASE + NREG + offset).
    localparam int CLR_ALIAS_OFS = 0;

    // Upper bound on NREG that the one-hot helper can represent.
    localparam int MAX_REG = 1024;

    function automatic logic [MAX_REG-1:0] onehot(input int idx, input int nreg);
        logic [MAX_REG-1:0] v;
        v = '0;
        if (idx >= 0 && idx < nreg && idx < MAX_REG)
            v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regwr_dec.sv
// Combinational address decode: hit, clear-alias and one-hot enable.
// Optional clear-all alias enabled by defining REGWR_GLOBAL_CLR_EN.
module regwr_dec
    import regwr_pkg::*;
#(
    parameter int AW   = 8,
    parameter int NREG = 8,
    parameter int BASE = 0
) (
    input  logic [AW-1:0]   addr,
    output logic            hit,
    output logic            clr,
    output logic [NREG-1:0] en
);

    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [AW-1:0] NREG_A = AW'(NREG);

    logic [AW:0]        diff;
    logic [AW-1:0]      idx;
    logic               above_base;
    logic [MAX_REG-1:0] sel;
    logic               spill;

    // Extra MSB acts as the borrow, so addr >= BASE needs no separate compare.
    assign diff       = {1'b0, addr} - {1'b0, BASE_A};
    assign idx        = diff[AW-1:0];
    assign above_base = !diff[AW];
    assign sel        = onehot(int'(idx), NREG);
    assign spill      = |sel[MAX_REG-1:NREG];
    assign hit        = above_base && (idx < NREG_A) && !spill;

`ifdef REGWR_GLOBAL_CLR_EN
    assign clr = above_base && (idx == AW'(NREG + CLR_ALIAS_OFS));
`else
    assign clr = 1'b0;
`endif

    always_comb begin
        en = '0;
        if (clr)
            en = '1;
        else if (hit)
            en = sel[NREG-1:0];
    end

endmodule

// File: rtl/regwr_strobe.sv
// Four-phase bus write front end driving one-cycle one-hot latch enables.
// Defining REGWR_GLOBAL_CLR_EN turns address BASE+NREG into a clear-all alias.
module regwr_strobe
    import regwr_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int BASE = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_req,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_ack,
    output logic [NREG-1:0] reg_en,
    output logic [DW-1:0]   reg_d,
    output logic            miss,
    output logic            busy
);

    localparam longint LAST_ADDR = longint'(BASE) + longint'(NREG) + longint'(CLR_ALIAS_OFS);

    generate
        if (NREG < 1 || NREG >= MAX_REG || BASE < 0 || LAST_ADDR > (64'sd1 <<< AW) - 1) begin : g_bad_params
            $error("regwr_strobe: NREG/BASE out of range for AW");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic            dec_hit, dec_clr;
    logic [NREG-1:0] dec_en;

    regwr_dec #(
        .AW   (AW),
        .NREG (NREG),
        .BASE (BASE)
    ) u_dec (
        .addr (addr_q),
        .hit  (dec_hit),
        .clr  (dec_clr),
        .en   (dec_en)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_req) state_d = DEC;
            DEC:     state_d = (dec_hit || dec_clr) ? STROBE : ACK;
            STROBE:  state_d = ACK;
            ACK:     if (!wr_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered off the current state, so each lags its state by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            reg_d   <= '0;
            reg_en  <= '0;
            miss    <= 1'b0;
            wr_ack  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && wr_req) begin
                addr_q <= wr_addr;
                reg_d  <= wr_data;
            end else if (state_q == STROBE && dec_clr) begin
                reg_d  <= '0;
            end
            reg_en <= (state_q == STROBE) ? dec_en : '0;
            miss   <= (state_q == DEC) && !dec_hit && !dec_clr;
            wr_ack <= (state_q == ACK) && wr_req;
            busy   <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_regwr_strobe.sv
// Self-checking bench for regwr_strobe (BASE=0x10, NREG=8); table vectors, random writes, reset corners.
module tb_regwr_strobe;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int BASE = 'h10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_req = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            wr_ack;
    logic [NREG-1:0] reg_en;
    logic [DW-1:0]   reg_d;
    logic            miss;
    logic            busy;

    int n_compared = 0;
    int n_mismatched = 0;

    regwr_strobe #(.AW(AW), .DW(DW), .NREG(NREG), .BASE(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .reg_en  (reg_en),
        .reg_d   (reg_d),
        .miss    (miss),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        int              hold;
        logic [NREG-1:0] exp_en;
        logic            exp_miss;
        logic [DW-1:0]   exp_d;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Reference: which register a write reaches and what the latch bank should end up seeing
    function automatic void refModel(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     output logic [NREG-1:0] en, output logic ms, output logic [DW-1:0] dout);
        int ai = int'(a);
        bit clr_alias = 1'b0;
`ifdef REGWR_GLOBAL_CLR_EN
        clr_alias = (ai == BASE + NREG);
`endif
        en = '0; ms = 1'b0; dout = d;
        if (ai >= BASE && ai < BASE + NREG)
            en = NREG'(1) << (ai - BASE);
        else if (clr_alias) begin
            en = '1; dout = '0;
        end else
            ms = 1'b1;
    endfunction

    // Assumes wr_req went high at the current negedge; the next posedge is E0.
    task automatic observeTxn(input string tag, input logic [DW-1:0] d, input int hold,
                              input logic [NREG-1:0] exp_en, input logic exp_miss, input logic [DW-1:0] exp_d);
        int k = 0, en_cnt = 0, en_k = -1, miss_cnt = 0, miss_k = -1, ack_k = -1;
        int ack_cycles = 0, overlap = 0, not_busy = 0;
        logic [NREG-1:0] en_val = '0;
        logic [DW-1:0] d_en = '0, d_k1 = '0;
        bit done = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            wr_addr = AW'($urandom);
            wr_data = DW'($urandom);
            if (reg_en != 0) begin en_cnt++; en_k = k; en_val = reg_en; d_en = reg_d; end
            if (miss) begin miss_cnt++; miss_k = k; end
            if (miss && reg_en != 0) overlap++;
            if (!busy) not_busy++;
            if (k == 1) d_k1 = reg_d;
            if (wr_ack) begin
                ack_cycles++;
                if (ack_k < 0) ack_k = k;
            end
            k++;
            if (ack_k >= 0 && k > ack_k + hold) done = 1'b1;
        end
        checkOutput({tag, " ack_latency"}, ack_k, (exp_en != 0) ? 3 : 2);
        checkOutput({tag, " ack_held"}, ack_cycles, hold + 1);
        checkOutput({tag, " en_pulses"}, en_cnt, (exp_en != 0) ? 1 : 0);
        checkOutput({tag, " en_value"}, en_val, exp_en);
        checkOutput({tag, " miss_pulses"}, miss_cnt, exp_miss ? 1 : 0);
        checkOutput({tag, " busy_held"}, not_busy, 0);
        checkOutput({tag, " miss_en_overlap"}, overlap, 0);
        if (exp_en != 0) begin
            checkOutput({tag, " en_cycle"}, en_k, 2);
            checkOutput({tag, " d_at_strobe"}, d_en, exp_d);
        end
        if (exp_miss) checkOutput({tag, " miss_cycle"}, miss_k, 1);
        if (exp_en != '1) checkOutput({tag, " d_after_E1"}, d_k1, d);
        wr_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, " ack_release"}, wr_ack, 0);
        checkOutput({tag, " idle_busy"}, busy, 0);
        checkOutput({tag, " d_stable"}, reg_d, exp_d);
    endtask

    task automatic applyStimulus(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int hold, input logic [NREG-1:0] exp_en, input logic exp_miss,
                                 input logic [DW-1:0] exp_d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        observeTxn(tag, d, hold, exp_en, exp_miss, exp_d);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{8'h13, 16'hBEEF, 0,  8'b0000_1000, 1'b0, 16'hBEEF});
        vecs.push_back('{8'h0F, 16'h0F0F, 0,  8'h00,        1'b1, 16'h0F0F});
`ifdef REGWR_GLOBAL_CLR_EN
        vecs.push_back('{8'h18, 16'h1234, 0,  8'hFF,        1'b0, 16'h0000});
`else
        vecs.push_back('{8'h18, 16'h1818, 0,  8'h00,        1'b1, 16'h1818});
`endif
        vecs.push_back('{8'h13, 16'h3333, 10, 8'b0000_1000, 1'b0, 16'h3333});
        vecs.push_back('{8'h17, 16'h7777, 0,  8'b1000_0000, 1'b0, 16'h7777});
        vecs.push_back('{8'h10, 16'h5555, 2,  8'b0000_0001, 1'b0, 16'h5555});
        vecs.push_back('{8'h00, 16'hA5A5, 0,  8'h00,        1'b1, 16'hA5A5});
        vecs.push_back('{8'hFF, 16'h5A5A, 1,  8'h00,        1'b1, 16'h5A5A});

        // Reset held with a pending request: nothing may move.
        reset = 1'b1; wr_req = 1'b1; wr_addr = 8'h13; wr_data = 16'hCAFE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("reset_en", reg_en, 0);
            checkOutput("reset_ack", wr_ack, 0);
            checkOutput("reset_outs", {miss, busy}, 0);
            checkOutput("reset_d", reg_d, 0);
        end
        reset = 1'b0;
        observeTxn("post_reset", 16'hCAFE, 0, 8'b0000_1000, 1'b0, 16'hCAFE);

        foreach (vecs[i])
            applyStimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].hold,
                          vecs[i].exp_en, vecs[i].exp_miss, vecs[i].exp_d);

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [NREG-1:0] e;
            logic m;
            logic [DW-1:0] xd;
            a = ($urandom_range(2) == 0) ? AW'($urandom) : AW'(8'h0C + $urandom_range(17));
            d = DW'($urandom);
            refModel(a, d, e, m, xd);
            applyStimulus($sformatf("rnd%0d_a%0h", i, a), a, d, int'($urandom_range(3)), e, m, xd);
        end

        // Reset landing while STROBE is in flight drops the strobe.
        wr_req = 1'b1; wr_addr = 8'h13; wr_data = 16'hABCD;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_en", reg_en, 0);
        checkOutput("mid_reset_ack", wr_ack, 0);
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_d", reg_d, 0);
        wr_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("after_reset_en", reg_en, 0);
        checkOutput("after_reset_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
